aesl_deadlock_monitor_n: RTL and testbench

Parametrised deadlock monitor for an N-process dataflow region. It watches per-process idle and ready-pending status, plus a wait-for adjacency matrix. When the blocked set stays stable, it walks the wait-for graph to find a cycle, then reports a sticky deadlock with the origin process and the cycle membership. It supersedes the fixed two-process detect/report unit pair and sits beside the dataflow top in the simulation and debug build.

---
 rtl/aesl_dl_pkg.sv | 45 ++++
 rtl/aesl_dl_prio_enc.sv | 28 ++
 rtl/aesl_deadlock_monitor_n.sv | 176 +++++++++++++++++
 tb/tb_aesl_deadlock_monitor_n.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aesl_dl_pkg.sv
// Shared types and helpers for the N-process deadlock monitor.
// Monitors with NPROC up to MAX_NPROC are supported by these helpers.
package aesl_dl_pkg;

    localparam int MAX_NPROC = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DETECTED
    } dl_state_e;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } lowest_t;

    // Lowest set bit of vec at or above min_idx; found=0 when none qualifies.
    function automatic lowest_t lowest_set(input logic [MAX_NPROC-1:0] vec,
                                           input int                   min_idx);
        lowest_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_NPROC - 1; i >= 0; i--) begin
            if (vec[i] && (i >= min_idx)) begin
                r.found = 1'b1;
                r.idx   = 32'(i);
            end
        end
        return r;
    endfunction

    // Row i of a flattened nproc x nproc wait-for matrix, upper bits zeroed.
    function automatic logic [MAX_NPROC-1:0] row(input logic [MAX_NPROC*MAX_NPROC-1:0] wf,
                                                 input int                             nproc,
                                                 input int                             i);
        logic [MAX_NPROC-1:0] r;
        r = MAX_NPROC'(wf >> (i * nproc));
        for (int j = 0; j < MAX_NPROC; j++) begin
            if (j >= nproc) r[j] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/aesl_dl_prio_enc.sv
// Lowest-set-bit encoder with a floor: bits below i_floor are ignored.
// i_floor is one bit wider than the index so "above the last process" is expressible.
module aesl_dl_prio_enc #(
    parameter int W     = 2,
    parameter int IDX_W = 1
) (
    input  logic [W-1:0]     i_vec,
    input  logic [IDX_W:0]   i_floor,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);
    import aesl_dl_pkg::*;

    logic [MAX_NPROC-1:0] w_vec_ext;
    lowest_t              w_res;

    // Zero-extend the request vector to the helper's fixed width.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_vec_ext        = '0;
        w_vec_ext[W-1:0] = i_vec;
    end

    assign w_res   = lowest_set(w_vec_ext, int'(i_floor));
    assign o_found = w_res.found;
    assign o_idx   = IDX_W'(w_res.idx);

endmodule

// File: rtl/aesl_deadlock_monitor_n.sv
// Deadlock monitor for an NPROC-process dataflow region.
// Waits for a stable non-empty blocked set, walks the wait-for graph one hop per
// cycle from each blocked candidate in turn, and reports the first cycle found.
// Optional macro AESL_DL_DISPLAY_EN prints one line per detection (simulation only).
module aesl_deadlock_monitor_n #(
    parameter int NPROC         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NPROC-1:0]                           proc_idle,
    input  logic [NPROC-1:0]                           proc_ready_pending,
    input  logic [NPROC*NPROC-1:0]                     wait_for,
    input  logic                                       clear,
    output logic                                       busy,
    output logic                                       dl_detect,
    output logic [((NPROC > 2) ? $clog2(NPROC) : 1)-1:0] dl_origin,
    output logic [NPROC-1:0]                           dl_cycle_mask
);
    import aesl_dl_pkg::*;

    localparam int IDX_W = (NPROC > 2) ? $clog2(NPROC) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] STEP_LAST = IDX_W'(NPROC - 1);

    dl_state_e          r_state, w_state_nxt;
    logic [NPROC-1:0]   r_blocked_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_origin, r_cur, r_step;
    logic [NPROC-1:0]   r_visited;
    logic [IDX_W-1:0]   r_dl_origin;
    logic [NPROC-1:0]   r_dl_cycle_mask;

    logic [NPROC-1:0]   w_blocked, w_row, w_edges;
    logic [MAX_NPROC*MAX_NPROC-1:0] w_wf_ext;
    logic               w_stable, w_changed, w_advance;
    logic               w_nxt_found, w_cand_found;
    logic [IDX_W-1:0]   w_nxt_idx, w_cand_idx;
    logic [IDX_W:0]     w_cand_floor;

    // When every process is pending the region is draining, so nothing counts as blocked.
    assign w_blocked = proc_idle & proc_ready_pending & ~{NPROC{&proc_ready_pending}};
    assign w_changed = (w_blocked != r_blocked_q);
    assign w_stable  = !w_changed && (|w_blocked);

    // Widen the wait-for matrix to the helper's fixed width.
    always_comb begin
        w_wf_ext                  = '0;
        w_wf_ext[NPROC*NPROC-1:0] = wait_for;
    end

    // Valid outgoing edges of the current walk node: blocked targets, no self loop.
    assign w_row   = NPROC'(row(w_wf_ext, NPROC, int'(r_cur)));
    assign w_edges = w_row & w_blocked & ~(NPROC'(1) << r_cur);

    // In IDLE the candidate is the lowest blocked process; in SCAN the next one above origin.
    assign w_cand_floor = (r_state == IDLE) ? '0 : ((IDX_W+1)'(r_origin) + (IDX_W+1)'(1));

    aesl_dl_prio_enc #(.W(NPROC), .IDX_W(IDX_W)) u_nxt_enc (
        .i_vec   (w_edges),
        .i_floor ('0),
        .o_found (w_nxt_found),
        .o_idx   (w_nxt_idx)
    );

    aesl_dl_prio_enc #(.W(NPROC), .IDX_W(IDX_W)) u_cand_enc (
        .i_vec   (w_blocked),
        .i_floor (w_cand_floor),
        .o_found (w_cand_found),
        .o_idx   (w_cand_idx)
    );

    // Take one more hop: an edge exists, it does not close the cycle, and the hop budget remains.
    assign w_advance = w_nxt_found && (w_nxt_idx != r_origin) && (r_step != STEP_LAST);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic; closing the cycle takes priority over exhausting the hop budget.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!clear && (r_cnt == CNT_MAX) && w_cand_found) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (clear || w_changed)                        w_state_nxt = IDLE;
                else if (w_nxt_found && w_nxt_idx == r_origin) w_state_nxt = DETECTED;
                else if (!w_advance && !w_cand_found)          w_state_nxt = IDLE;
            end
            DETECTED: begin
                if (clear) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy          = (r_state == SCAN);
        dl_detect     = (r_state == DETECTED);
        dl_origin     = r_dl_origin;
        dl_cycle_mask = r_dl_cycle_mask;
    end

    // Stability tracking: counter restarts on any change, on clear and outside IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blocked_q <= '0;
            r_cnt       <= '0;
        end else begin
            r_blocked_q <= w_blocked;
            if (r_state != IDLE || clear || !w_stable) r_cnt <= '0;
            else if (r_cnt != CNT_MAX)                 r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Graph walk: load a fresh candidate or take one hop along the lowest-index edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_origin  <= '0;
            r_cur     <= '0;
            r_step    <= '0;
            r_visited <= '0;
        end else if (w_state_nxt == SCAN) begin
            if (r_state == SCAN && w_advance) begin
                r_cur     <= w_nxt_idx;
                r_visited <= r_visited | (NPROC'(1) << w_nxt_idx);
                r_step    <= r_step + IDX_W'(1);
            end else begin
                r_origin  <= w_cand_idx;
                r_cur     <= w_cand_idx;
                r_visited <= NPROC'(1) << w_cand_idx;
                r_step    <= '0;
            end
        end
    end

    // Report registers: latched on entry to DETECTED, held there, zero otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dl_origin     <= '0;
            r_dl_cycle_mask <= '0;
        end else if (w_state_nxt == DETECTED) begin
            if (r_state == SCAN) begin
                r_dl_origin     <= r_origin;
                r_dl_cycle_mask <= r_visited;
            end
        end else begin
            r_dl_origin     <= '0;
            r_dl_cycle_mask <= '0;
        end
    end

`ifdef AESL_DL_DISPLAY_EN
    string r_members;

    // One report line on the edge that enters DETECTED.
    always @(posedge clock) begin
        if (!reset && r_state == SCAN && w_state_nxt == DETECTED) begin
            r_members = "";
            for (int i = 0; i < NPROC; i++) begin
                if (r_visited[i]) r_members = {r_members, $sformatf(" %0d", i)};
            end
            $display("%0t aesl_deadlock_monitor_n: deadlock origin=%0d cycle_mask=%b members:%s",
                     $time, r_origin, r_visited, r_members);
        end
    end
`endif

endmodule

// File: tb/tb_aesl_deadlock_monitor_n.sv
// Bench for aesl_deadlock_monitor_n: three instances (NPROC=2, 3, 5).
// Expected detections are queued by the stimulus and consumed by a monitor.
module tb_aesl_deadlock_monitor_n;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // NPROC=2 instance
    logic [1:0]  idle2, pend2, mask2;
    logic [3:0]  wf2;
    logic        clr2, busy2, det2;
    logic [0:0]  org2;
    // NPROC=3 instance
    logic [2:0]  idle3, pend3, mask3;
    logic [8:0]  wf3;
    logic        clr3, busy3, det3;
    logic [1:0]  org3;
    // NPROC=5 instance
    logic [4:0]  idle5, pend5, mask5;
    logic [24:0] wf5;
    logic        clr5, busy5, det5;
    logic [2:0]  org5;

    aesl_deadlock_monitor_n #(.NPROC(2), .STABLE_CYCLES(4)) u2 (
        .clock(clock), .reset(reset), .proc_idle(idle2), .proc_ready_pending(pend2),
        .wait_for(wf2), .clear(clr2), .busy(busy2), .dl_detect(det2),
        .dl_origin(org2), .dl_cycle_mask(mask2));

    aesl_deadlock_monitor_n #(.NPROC(3), .STABLE_CYCLES(4)) u3 (
        .clock(clock), .reset(reset), .proc_idle(idle3), .proc_ready_pending(pend3),
        .wait_for(wf3), .clear(clr3), .busy(busy3), .dl_detect(det3),
        .dl_origin(org3), .dl_cycle_mask(mask3));

    aesl_deadlock_monitor_n #(.NPROC(5), .STABLE_CYCLES(4)) u5 (
        .clock(clock), .reset(reset), .proc_idle(idle5), .proc_ready_pending(pend5),
        .wait_for(wf5), .clear(clr5), .busy(busy5), .dl_detect(det5),
        .dl_origin(org5), .dl_cycle_mask(mask5));

    typedef struct {
        int          inst;
        int unsigned at;
        logic [7:0]  origin;
        logic [7:0]  mask;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_detect(input int inst, input int unsigned at,
                                 input logic [7:0] origin, input logic [7:0] mask);
        exp_t e;
        e.inst = inst; e.at = at; e.origin = origin; e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic score(input int inst, input logic [7:0] origin, input logic [7:0] mask);
        exp_t e;
        if (exp_q.size() == 0 || exp_q[0].inst != inst) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_detect: instance nproc=%0d asserted dl_detect at cycle %0d", inst, cyc);
        end else begin
            e = exp_q.pop_front();
            check("detect_cycle",  cyc,    e.at);
            check("dl_origin",     origin, e.origin);
            check("dl_cycle_mask", mask,   e.mask);
        end
    endtask

    // Monitor: sample on the falling edge, score every rising dl_detect.
    logic d2_q = 1'b0, d3_q = 1'b0, d5_q = 1'b0, busy2_seen = 1'b0;
    always @(negedge clock) begin
        if (det2 && !d2_q) score(2, 8'(org2), 8'(mask2));
        if (det3 && !d3_q) score(3, 8'(org3), 8'(mask3));
        if (det5 && !d5_q) score(5, 8'(org5), 8'(mask5));
        if (busy2) busy2_seen <= 1'b1;
        d2_q <= det2;
        d3_q <= det3;
        d5_q <= det5;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int unsigned t, c;

    initial begin
        reset = 1'b1;
        idle2 = '0; pend2 = '0; wf2 = '0; clr2 = 1'b0;
        idle3 = '0; pend3 = '0; wf3 = '0; clr3 = 1'b0;
        idle5 = '0; pend5 = '0; wf5 = '0; clr5 = 1'b0;
        tick(3);
        check("reset_busy",      busy3, 0);
        check("reset_detect",    det3,  0);
        check("reset_origin",    org3,  0);
        check("reset_mask",      mask3, 0);
        reset = 1'b0;
        tick(2);

        // NPROC=2: all pending -> nothing blocked despite a 2-cycle in wait_for
        idle2 = 2'b11; pend2 = 2'b11; wf2 = 4'b0110;
        tick(20);
        check("allpending_detect", det2, 0);

        // NPROC=2: blocked set alternates every cycle -> never stable
        for (int k = 0; k < 20; k++) begin
            pend2 = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick(1);
        end
        check("oscillate_detect", det2, 0);
        idle2 = '0; pend2 = '0; wf2 = '0;
        tick(3);

        // NPROC=3: 0 <-> 2 cycle, blocked from cycle t
        t = cyc;
        idle3 = 3'b101; pend3 = 3'b101; wf3 = 9'h044;
        expect_detect(3, t + 8, 8'd0, 8'b101);
        tick(5);
        check("busy_before_scan", busy3, 0);
        tick(1);
        check("busy_at_scan",     busy3, 1);
        tick(2);
        check("busy_in_detected", busy3, 0);
        tick(2);

        // clear while DETECTED, condition persists -> rescan and re-detect
        c = cyc;
        clr3 = 1'b1;
        expect_detect(3, c + 8, 8'd0, 8'b101);
        tick(1);
        clr3 = 1'b0;
        check("clear_detect", det3,  0);
        check("clear_origin", org3,  0);
        check("clear_mask",   mask3, 0);
        tick(7);

        // reset while DETECTED
        reset = 1'b1;
        tick(1);
        check("rst_det_detect", det3,  0);
        check("rst_det_mask",   mask3, 0);
        check("rst_det_busy",   busy3, 0);
        reset = 1'b0;

        // condition still held: scan restarts; reset on its second cycle beats detection
        tick(7);
        check("busy_second_scan_cycle", busy3, 1);
        reset = 1'b1;
        tick(1);
        check("rst_scan_busy",   busy3, 0);
        check("rst_scan_detect", det3,  0);
        reset = 1'b0;
        idle3 = '0;
        tick(3);

        // abort: blocked set changes on the first SCAN cycle
        t = cyc;
        idle3 = 3'b101;
        tick(6);
        check("abort_busy_scan", busy3, 1);
        idle3 = 3'b001;
        tick(1);
        check("abort_busy_drop", busy3, 0);
        // lone blocked process without edges: periodic rescan that finds nothing
        tick(5);
        check("rescan_busy",      busy3, 1);
        tick(1);
        check("rescan_exhausted", busy3, 0);
        idle3 = '0; pend3 = '0; wf3 = '0;
        tick(3);

        // NPROC=5: candidate 0 dead-ends at 1, candidate 1 has no edge, candidate 2 closes 2<->3
        t = cyc;
        idle5 = 5'b01111; pend5 = 5'b01111; wf5 = 25'h0022002;
        expect_detect(5, t + 11, 8'd2, 8'b01100);
        tick(14);
        check("multi_cand_held", det5, 1);
        clr5 = 1'b1;
        idle5 = '0; pend5 = '0; wf5 = '0;
        tick(1);
        clr5 = 1'b0;
        tick(5);

        check("queue_drained",      exp_q.size(), 0);
        check("nproc2_busy_never",  busy2_seen,   0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
